// File: rtl/uart_ctrl.sv
// UART sequencing controller: feeds the transmitter from the TX FIFO, arms the receiver,
// commits clean received frames to the RX FIFO and keeps saturating status counters.
module uart_ctrl #(
    parameter int data_wd        = 8,
    parameter int cnt_wd         = 16,
    parameter int timeout_cycles = 2_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_enable,
    input  logic              rx_enable,
    input  logic              tx_empty,
    input  logic              tx_busy,
    input  logic              tx_done,
    input  logic              rx_full,
    input  logic              rx_done,
    input  logic              framing_error_flag,
    input  logic              parity_error_flag,
    output logic              tx_rd_en,
    output logic              tx_start,
    output logic              rx_start,
    output logic              rx_wr_en,
    output logic [cnt_wd-1:0] tx_frame_cnt,
    output logic [cnt_wd-1:0] rx_frame_cnt,
    output logic [cnt_wd-1:0] rx_drop_cnt,
    output logic [cnt_wd-1:0] timeout_cnt
);

    localparam int TMR_W = (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(timeout_cycles - 1);
    localparam logic [cnt_wd-1:0] CNT_MAX  = '1;

    if (timeout_cycles < 2 || data_wd < 1) begin : g_param_chk
        $error("uart_ctrl: timeout_cycles must be >= 2 and data_wd >= 1");
    end

    typedef enum logic [1:0] {T_IDLE, T_POP, T_LOAD, T_WAIT} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ARM, R_WAIT} rx_state_t;

    function automatic logic [cnt_wd-1:0] sat_add(input logic [cnt_wd-1:0] a,
                                                  input logic [1:0]        b);
        logic [cnt_wd:0] sum;
        sum = {1'b0, a} + (cnt_wd + 1)'(b);
        return (sum > {1'b0, CNT_MAX}) ? CNT_MAX : sum[cnt_wd-1:0];
    endfunction

    tx_state_t         r_tx_state;
    rx_state_t         r_rx_state;
    logic [TMR_W-1:0]  r_tx_tmr;
    logic [TMR_W-1:0]  r_rx_tmr;
    logic              r_tx_rd_en;
    logic              r_tx_start;
    logic              r_rx_start;
    logic              r_rx_wr_en;
    logic [cnt_wd-1:0] r_tx_frame_cnt;
    logic [cnt_wd-1:0] r_rx_frame_cnt;
    logic [cnt_wd-1:0] r_rx_drop_cnt;
    logic [cnt_wd-1:0] r_timeout_cnt;

    logic       w_tx_req;
    logic       w_tx_to;
    logic       w_rx_to;
    logic       w_rx_good;
    logic [1:0] w_to_sum;

    assign w_tx_req  = tx_enable && !tx_empty && !tx_busy;
    // A done arriving in the last timer cycle takes priority over the timeout.
    assign w_tx_to   = (r_tx_state == T_WAIT) && !tx_done && (r_tx_tmr == TMR_LAST);
    assign w_rx_to   = (r_rx_state == R_WAIT) && !rx_done && (r_rx_tmr == TMR_LAST);
    assign w_rx_good = !framing_error_flag && !parity_error_flag && !rx_full;
    assign w_to_sum  = {1'b0, w_tx_to} + {1'b0, w_rx_to};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state     <= T_IDLE;
            r_tx_rd_en     <= 1'b0;
            r_tx_start     <= 1'b0;
            r_tx_tmr       <= '0;
            r_tx_frame_cnt <= '0;
        end else begin
            r_tx_rd_en <= 1'b0;
            r_tx_start <= 1'b0;
            case (r_tx_state)
                T_IDLE: begin
                    if (w_tx_req) begin
                        r_tx_state <= T_POP;
                        r_tx_rd_en <= 1'b1;
                    end
                end
                T_POP: r_tx_state <= T_LOAD;
                T_LOAD: begin
                    r_tx_start <= 1'b1;
                    r_tx_tmr   <= '0;
                    r_tx_state <= T_WAIT;
                end
                T_WAIT: begin
                    if (tx_done) begin
                        r_tx_frame_cnt <= sat_add(r_tx_frame_cnt, 2'd1);
                        // Chain straight into the next pop when another byte is ready.
                        if (w_tx_req) begin
                            r_tx_state <= T_POP;
                            r_tx_rd_en <= 1'b1;
                        end else begin
                            r_tx_state <= T_IDLE;
                        end
                    end else if (w_tx_to) begin
                        r_tx_state <= T_IDLE;
                    end else begin
                        r_tx_tmr <= r_tx_tmr + TMR_W'(1);
                    end
                end
                default: r_tx_state <= T_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state     <= R_IDLE;
            r_rx_start     <= 1'b0;
            r_rx_wr_en     <= 1'b0;
            r_rx_tmr       <= '0;
            r_rx_frame_cnt <= '0;
            r_rx_drop_cnt  <= '0;
        end else begin
            r_rx_start <= 1'b0;
            r_rx_wr_en <= 1'b0;
            case (r_rx_state)
                R_IDLE: begin
                    if (rx_enable && !rx_full) begin
                        r_rx_state <= R_ARM;
                    end
                end
                R_ARM: begin
                    r_rx_start <= 1'b1;
                    r_rx_tmr   <= '0;
                    r_rx_state <= R_WAIT;
                end
                R_WAIT: begin
                    if (rx_done) begin
                        r_rx_frame_cnt <= sat_add(r_rx_frame_cnt, 2'd1);
                        if (w_rx_good) begin
                            r_rx_wr_en <= 1'b1;
                        end else begin
                            r_rx_drop_cnt <= sat_add(r_rx_drop_cnt, 2'd1);
                        end
                        r_rx_state <= R_IDLE;
                    end else if (w_rx_to) begin
                        r_rx_state <= R_IDLE;
                    end else begin
                        r_rx_tmr <= r_rx_tmr + TMR_W'(1);
                    end
                end
                default: r_rx_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout_cnt <= '0;
        end else if (w_tx_to || w_rx_to) begin
            r_timeout_cnt <= sat_add(r_timeout_cnt, w_to_sum);
        end
    end

    assign tx_rd_en     = r_tx_rd_en;
    assign tx_start     = r_tx_start;
    assign rx_start     = r_rx_start;
    assign rx_wr_en     = r_rx_wr_en;
    assign tx_frame_cnt = r_tx_frame_cnt;
    assign rx_frame_cnt = r_rx_frame_cnt;
    assign rx_drop_cnt  = r_rx_drop_cnt;
    assign timeout_cnt  = r_timeout_cnt;

endmodule
